vga_scan_out: RTL and testbench
===============================

VGA_SCAN_OUT -- requirements
Module: vga_scan_out

Interface
REQ-001 Parameter DATA_W, 24: pixel width, {R[23:16],G[15:8],B[7:0]}.
REQ-002 Parameters H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48: horizontal timing in pixels.
REQ-003 Parameters V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33: vertical timing in lines.
REQ-004 Parameters HS_POL/VS_POL, 0/0: active level of the sync pulses.
REQ-005 Reset is reset_rd, asynchronous, active-high; clock is rd_clk.
REQ-006 Ports:
- rd_clk  in  1  pixel clock
- reset_rd  in  1  async active-high reset
- fifo_empty  in  1  show-ahead FIFO empty
- fifo_data  in  DATA_W  head-of-FIFO pixel, valid when fifo_empty=0
- fifo_rd  out  1  pop strobe, combinational
- clr_underflow  in  1  clears the underflow flag
- vga_r/vga_g/vga_b  out  8 each  pixel colour
- vga_hs/vga_vs  out  1 each  sync
- vga_blank_n  out  1  low outside the active area
- vblank_start  out  1  one-cycle pulse to the upstream fetch logic
- underflow  out  1  sticky underflow flag

Function
REQ-007 h_cnt runs 0..H_TOTAL-1 and wraps to 0; v_cnt increments on each h wrap and wraps to 0 after V_TOTAL-1; H_TOTAL = sum of the H parameters, V_TOTAL = sum of the V parameters.
REQ-008 Region order is active, front porch, sync, back porch; active = h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-009 All VGA outputs are registered with a latency of exactly 1 cycle after the counter state; hs, vs, blank_n and colour stay mutually aligned.
REQ-010 State machine IDLE/RUN/DROP; reset state is IDLE.
REQ-011 IDLE: no pops; black colour; timing still runs. Transition to RUN at h_cnt=0,v_cnt=0 if fifo_empty=0, otherwise remain in IDLE for that frame.
REQ-012 On entry to RUN, pix_left loads H_ACTIVE*V_ACTIVE.
REQ-013 RUN, active pixel, fifo_empty=0: fifo_rd=1, next colour=fifo_data, pix_left decrements.
REQ-014 RUN, active pixel, fifo_empty=1: fifo_rd=0, next colour black, underflow set, transition to DROP.
REQ-015 RUN with pix_left reaching 0 returns to IDLE.
REQ-016 DROP: fifo_rd=fifo_empty==0 && pix_left!=0, independent of timing; popped data is discarded and the colour output is black.
REQ-017 DROP transitions to IDLE when pix_left=0, including when that occurs in a later frame.
REQ-018 fifo_rd is never asserted while fifo_empty=1.
REQ-019 vblank_start is a 1-cycle pulse at h_cnt=0, v_cnt=V_ACTIVE, output-aligned with the other registered outputs.
REQ-020 underflow is set by REQ-014 and cleared by clr_underflow; a set and a clear in the same cycle leave underflow set.
REQ-021 pix_left width is clog2(H_ACTIVE*V_ACTIVE+1).

Reset
REQ-022 Reset values:
- h_cnt=0, v_cnt=0, pix_left=0, state IDLE
- colour 0, vga_blank_n=0
- vga_hs=~HS_POL, vga_vs=~VS_POL
- vblank_start=0, underflow=0
REQ-023 fifo_rd=0 while reset_rd is high.
REQ-024 Reset mid-frame abandons the frame; no pops occur until the next frame start with data present.

Configuration
REQ-025 Macro VGA_TEST_PATTERN_EN, when defined, adds input test_mode (1 bit).
- test_mode=1: no pops, state forced to IDLE.
- Active pixels show 8 vertical colour bars of width H_ACTIVE/8, in the order white, yellow, cyan, green, magenta, red, blue, black.
REQ-026 Without VGA_TEST_PATTERN_EN, the test_mode port and the bar logic are absent.

Structure
REQ-027 A shared package vga_pkg holds:
- the state enum
- default 640x480 timing constants
- a localparam H_TOTAL/V_TOTAL helper
REQ-028 One sub-module, vga_timing_gen, holds h_cnt/v_cnt, the region decode and the sync/blank/vblank_start generation; the top level holds the FSM, pix_left, FIFO pop and colour registers.

Verification
REQ-029 Test timing is H=8/1/2/1, V=4/1/1/1 (H_TOTAL=12, V_TOTAL=7).
REQ-030 Timing: 2 frames with the FIFO empty -> hs low at h=9..10, vs low at v=5, blank_n high for 32 cycles per frame, state stays IDLE.
REQ-031 Streaming: 32 pixels 0x000001..0x000020 preloaded -> 32 pops, colours appear in order 1 cycle after the active counts, underflow=0, state returns to IDLE.
REQ-032 Underflow: only 10 pixels preloaded -> pixel 11 is black, underflow=1, DROP; 22 more pixels arrive later -> all 22 are popped and discarded, then IDLE; the next frame start with data present enters RUN.
REQ-033 Clear race: clr_underflow pulsed in the same cycle as an underflow event -> underflow stays 1; a later clr_underflow alone -> 0.
REQ-034 Reset mid-frame: reset_rd asserted at h=3,v=1 -> all outputs at reset values, fifo_rd=0; after release, the first pop occurs at the next h=0,v=0.
REQ-035 With VGA_TEST_PATTERN_EN and test_mode=1: 8 bars of width 1 starting with 0xFFFFFF, in the order of REQ-025, and no pops.

Source files
------------

// File: rtl/vga_pkg.sv
// ============================================================================
// vga_pkg : shared types and default 640x480 timing for the VGA scan-out block
// Revision : 1.0
// ============================================================================
`default_nettype none

package vga_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    function automatic int timing_total(input int active, input int fp,
                                        input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int DEF_H_TOTAL = timing_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL = timing_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

    // Colour-bar palette, left to right
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return 24'hFFFFFF;
            3'd1:    return 24'hFFFF00;
            3'd2:    return 24'h00FFFF;
            3'd3:    return 24'h00FF00;
            3'd4:    return 24'hFF00FF;
            3'd5:    return 24'hFF0000;
            3'd6:    return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// vga_timing_gen : h/v counters, region decode, registered sync/blank/vblank
// Revision : 1.0
// ============================================================================
`default_nettype none

module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic          rd_clk,
    input  logic          reset_rd,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          active,
    output logic          vga_hs,
    output logic          vga_vs,
    output logic          vga_blank_n,
    output logic          vblank_start
);

    localparam logic [HW-1:0] C_H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] C_H_ACT      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] C_HS_START   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] C_HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] C_V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] C_V_ACT      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] C_VS_START   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] C_VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          hs_q, vs_q, blank_n_q, vbs_q;
    logic          w_active, w_hs, w_vs, w_vbs;

    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q == C_H_LAST) begin
            h_d = '0;
            v_d = (v_q == C_V_LAST) ? '0 : v_q + 1'b1;
        end
    end

    assign w_active = (h_q < C_H_ACT) && (v_q < C_V_ACT);
    assign w_hs     = (h_q >= C_HS_START) && (h_q < C_HS_END);
    assign w_vs     = (v_q >= C_VS_START) && (v_q < C_VS_END);
    assign w_vbs    = (h_q == '0) && (v_q == C_V_ACT);

    // Outputs are registered from the current count so they line up with the colour register
    always_ff @(posedge rd_clk or posedge reset_rd) begin
        if (reset_rd) begin
            h_q       <= '0;
            v_q       <= '0;
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
            blank_n_q <= 1'b0;
            vbs_q     <= 1'b0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            hs_q      <= w_hs ? HS_POL : ~HS_POL;
            vs_q      <= w_vs ? VS_POL : ~VS_POL;
            blank_n_q <= w_active;
            vbs_q     <= w_vbs;
        end
    end

    assign h_cnt        = h_q;
    assign v_cnt        = v_q;
    assign active       = w_active;
    assign vga_hs       = hs_q;
    assign vga_vs       = vs_q;
    assign vga_blank_n  = blank_n_q;
    assign vblank_start = vbs_q;

endmodule

`default_nettype wire

// File: rtl/vga_scan_out.sv
// ============================================================================
// vga_scan_out : streams pixels from a show-ahead FIFO onto VGA with underflow
//                recovery. Optional colour bars via VGA_TEST_PATTERN_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vga_scan_out
    import vga_pkg::*;
#(
    parameter int DATA_W   = 24,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic              rd_clk,
    input  logic              reset_rd,
`ifdef VGA_TEST_PATTERN_EN
    input  logic              test_mode,
`endif
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd,
    input  logic              clr_underflow,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_blank_n,
    output logic              vblank_start,
    output logic              underflow
);

    localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int PW      = $clog2(H_ACTIVE * V_ACTIVE + 1);
    localparam logic [PW-1:0] C_PIX_TOTAL = PW'(H_ACTIVE * V_ACTIVE);

    logic [HW-1:0]     w_h;
    logic [VW-1:0]     w_v;
    logic              w_active;
    logic              w_frame_start;
    logic [PW-1:0]     w_pix_base, w_pix_dec;
    logic              w_rd, w_uf_set;

    state_e            state_q, state_d;
    logic [PW-1:0]     pix_left_q, pix_left_d;
    logic [DATA_W-1:0] colour_q, colour_d;
    logic              underflow_q;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HS_POL   (HS_POL),
        .VS_POL   (VS_POL)
    ) u_timing (
        .rd_clk       (rd_clk),
        .reset_rd     (reset_rd),
        .h_cnt        (w_h),
        .v_cnt        (w_v),
        .active       (w_active),
        .vga_hs       (vga_hs),
        .vga_vs       (vga_vs),
        .vga_blank_n  (vga_blank_n),
        .vblank_start (vblank_start)
    );

    assign w_frame_start = (w_h == '0) && (w_v == '0);
    // IDLE joins RUN on the frame's first pixel, so that pixel is popped in the same cycle
    assign w_pix_base    = (state_q == ST_IDLE) ? C_PIX_TOTAL : pix_left_q;
    assign w_pix_dec     = w_pix_base - 1'b1;

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    logic [2:0] w_bar_idx;
    assign w_bar_idx = 3'(32'(w_h) / BAR_W);
`endif

    always_comb begin
        state_d    = state_q;
        pix_left_d = pix_left_q;
        colour_d   = '0;
        w_rd       = 1'b0;
        w_uf_set   = 1'b0;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if ((state_q == ST_RUN) || (w_frame_start && !fifo_empty)) begin
                    state_d    = ST_RUN;
                    pix_left_d = w_pix_base;
                    if (w_active) begin
                        if (!fifo_empty) begin
                            w_rd       = 1'b1;
                            colour_d   = fifo_data;
                            pix_left_d = w_pix_dec;
                            if (w_pix_dec == '0) begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            w_uf_set = 1'b1;
                            state_d  = ST_DROP;
                        end
                    end
                end
            end
            ST_DROP: begin
                // Drain the rest of the abandoned frame regardless of raster position
                w_rd = !fifo_empty && (pix_left_q != '0);
                if (w_rd) begin
                    pix_left_d = pix_left_q - 1'b1;
                end
                if (pix_left_d == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef VGA_TEST_PATTERN_EN
        if (test_mode) begin
            state_d  = ST_IDLE;
            w_rd     = 1'b0;
            w_uf_set = 1'b0;
            colour_d = w_active ? DATA_W'(bar_colour(w_bar_idx)) : '0;
        end
`endif
    end

    always_ff @(posedge rd_clk or posedge reset_rd) begin
        if (reset_rd) begin
            state_q     <= ST_IDLE;
            pix_left_q  <= '0;
            colour_q    <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_left_q  <= pix_left_d;
            colour_q    <= colour_d;
            underflow_q <= w_uf_set | (underflow_q & ~clr_underflow);
        end
    end

    assign fifo_rd   = w_rd & ~reset_rd;
    assign vga_r     = colour_q[23:16];
    assign vga_g     = colour_q[15:8];
    assign vga_b     = colour_q[7:0];
    assign underflow = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_scan_out.sv
// ============================================================================
// tb_vga_scan_out : directed scoreboard bench for vga_scan_out (12x7 raster)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vga_scan_out;
    import vga_pkg::*;

    localparam int HA = 8, HF = 1, HS = 2, HB = 1;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic        rd_clk = 1'b0;
    logic        reset_rd = 1'b1;
    logic        fifo_empty = 1'b1;
    logic [23:0] fifo_data = 24'h0;
    logic        clr_underflow = 1'b0;
    logic        fifo_rd, vga_hs, vga_vs, vga_blank_n, vblank_start, underflow;
    logic [7:0]  vga_r, vga_g, vga_b;
`ifdef VGA_TEST_PATTERN_EN
    logic        test_mode = 1'b0;
`endif

    int          checks = 0;
    int          errors = 0;
    int          pop_cnt = 0;
    int          blank_cnt = 0;
    int          p0;
    logic [23:0] fifo_q[$];
    logic [23:0] exp_q[$];
    int          mh = 0, mv = 0, ph = 0, pv = 0;
    bit          ov = 1'b0;
    logic        pop_take;

    always #5 rd_clk = ~rd_clk;

    vga_scan_out #(
        .DATA_W(24), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .rd_clk        (rd_clk),
        .reset_rd      (reset_rd),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode     (test_mode),
`endif
        .fifo_empty    (fifo_empty),
        .fifo_data     (fifo_data),
        .fifo_rd       (fifo_rd),
        .clr_underflow (clr_underflow),
        .vga_r         (vga_r),
        .vga_g         (vga_g),
        .vga_b         (vga_b),
        .vga_hs        (vga_hs),
        .vga_vs        (vga_vs),
        .vga_blank_n   (vga_blank_n),
        .vblank_start  (vblank_start),
        .underflow     (underflow)
    );

    function automatic void refresh();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? 24'h0 : fifo_q[0];
    endfunction

    // Show-ahead FIFO model: pop is sampled at the edge, applied just after it
    always @(posedge rd_clk) pop_take <= fifo_rd;
    always begin
        @(posedge rd_clk);
        #1;
        if (pop_take && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            pop_cnt++;
        end
        refresh();
    end

    // Raster model: (mh,mv) is the live count, (ph,pv) the count the outputs show
    always @(posedge rd_clk or posedge reset_rd) begin
        if (reset_rd) begin
            mh <= 0; mv <= 0; ph <= 0; pv <= 0; ov <= 1'b0;
        end else begin
            ph <= mh;
            pv <= mv;
            ov <= 1'b1;
            mh <= (mh == HT - 1) ? 0 : mh + 1;
            if (mh == HT - 1) mv <= (mv == VT - 1) ? 0 : mv + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic        exp_act;
        logic [23:0] e;
        @(negedge rd_clk);
        chk("rd_when_empty", 32'(fifo_rd & fifo_empty), 0);
        if (reset_rd) chk("rd_in_reset", 32'(fifo_rd), 0);
        exp_act = ov && (ph < HA) && (pv < VA);
        chk("hs", 32'(vga_hs), (ov && ph >= HA + HF && ph < HA + HF + HS) ? 0 : 1);
        chk("vs", 32'(vga_vs), (ov && pv >= VA + VF && pv < VA + VF + VS) ? 0 : 1);
        chk("blank_n", 32'(vga_blank_n), 32'(exp_act));
        chk("vblank_start", 32'(vblank_start), (ov && ph == 0 && pv == VA) ? 1 : 0);
        e = 24'h0;
        if (exp_act && exp_q.size() > 0) e = exp_q.pop_front();
        chk("colour", 32'({vga_r, vga_g, vga_b}), 32'(e));
        blank_cnt += 32'(vga_blank_n);
    endtask

    task automatic goto(input int h, input int v);
        int n = 0;
        while (!(mh == h && mv == v) && n < 4 * HT * VT) begin
            step();
            n++;
        end
        chk("goto_bound", (mh == h && mv == v) ? 1 : 0, 1);
    endtask

    task automatic push(input logic [23:0] d, input bit expect_it);
        fifo_q.push_back(d);
        if (expect_it) exp_q.push_back(d);
        refresh();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [23:0] bars [8];
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

        // Reset state
        repeat (3) step();
        chk("rst_underflow", 32'(underflow), 0);
        chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        chk("rst_pix_left", 32'(dut.pix_left_q), 0);
        reset_rd = 1'b0;

        // Two empty frames: timing only, no pops
        blank_cnt = 0;
        repeat (2 * HT * VT) step();
        chk("blank_cycles", blank_cnt, 2 * HA * VA);
        chk("idle_state", 32'(dut.state_q), 32'(ST_IDLE));
        chk("idle_pops", pop_cnt, 0);

        // Full frame streaming
        goto(0, VA + 1);
        for (int i = 1; i <= HA * VA; i++) push(24'(i), 1'b1);
        p0 = pop_cnt;
        step();
        goto(0, VA + 1);
        chk("stream_pops", pop_cnt - p0, HA * VA);
        chk("stream_underflow", 32'(underflow), 0);
        chk("stream_state", 32'(dut.state_q), 32'(ST_IDLE));
        chk("stream_sb_left", exp_q.size(), 0);

        // Underflow after 10 pixels, then late data drained in DROP
        for (int i = 0; i < 10; i++) push(24'h0A0000 + 24'(i), 1'b1);
        for (int i = 0; i < HA * VA - 10; i++) exp_q.push_back(24'h0);
        step();
        goto(0, VA);
        chk("uf_flag", 32'(underflow), 1);
        chk("uf_state_drop", 32'(dut.state_q), 32'(ST_DROP));
        chk("uf_sb_left", exp_q.size(), 0);
        p0 = pop_cnt;
        for (int i = 0; i < HA * VA - 10; i++) push(24'h0B0000 + 24'(i), 1'b0);
        repeat (30) step();
        chk("drop_pops", pop_cnt - p0, HA * VA - 10);
        chk("drop_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
        chk("drop_fifo_empty", 32'(fifo_empty), 1);
        for (int i = 0; i < HA * VA; i++) push(24'h0C0000 + 24'(i), 1'b1);
        p0 = pop_cnt;
        goto(1, 0);
        chk("rerun_state", 32'(dut.state_q), 32'(ST_RUN));
        goto(0, VA + 1);
        chk("rerun_pops", pop_cnt - p0, HA * VA);
        chk("uf_sticky", 32'(underflow), 1);
        chk("rerun_idle", 32'(dut.state_q), 32'(ST_IDLE));

        // Clear racing an underflow event
        clr_underflow = 1'b1;
        step();
        clr_underflow = 1'b0;
        chk("clr_alone_1", 32'(underflow), 0);
        for (int i = 0; i < 5; i++) push(24'h0D0000 + 24'(i), 1'b1);
        for (int i = 0; i < HA * VA - 5; i++) exp_q.push_back(24'h0);
        goto(5, 0);
        chk("race_pre_empty", 32'(fifo_empty), 1);
        chk("race_pre_run", 32'(dut.state_q), 32'(ST_RUN));
        clr_underflow = 1'b1;
        step();
        clr_underflow = 1'b0;
        chk("race_set_wins", 32'(underflow), 1);
        chk("race_state_drop", 32'(dut.state_q), 32'(ST_DROP));
        clr_underflow = 1'b1;
        step();
        clr_underflow = 1'b0;
        chk("clr_alone_2", 32'(underflow), 0);
        goto(0, VA);
        for (int i = 0; i < HA * VA - 5; i++) push(24'h0E0000 + 24'(i), 1'b0);
        repeat (30) step();
        chk("race_drain_idle", 32'(dut.state_q), 32'(ST_IDLE));
        chk("race_drain_empty", 32'(fifo_empty), 1);

        // Reset in the middle of a streaming frame
        for (int i = 0; i < HA * VA; i++) push(24'h0F0000 + 24'(i), 1'b1);
        goto(3, 1);
        reset_rd = 1'b1;
        #1;
        chk("mr_hs", 32'(vga_hs), 1);
        chk("mr_vs", 32'(vga_vs), 1);
        chk("mr_blank_n", 32'(vga_blank_n), 0);
        chk("mr_colour", 32'({vga_r, vga_g, vga_b}), 0);
        chk("mr_vblank", 32'(vblank_start), 0);
        chk("mr_underflow", 32'(underflow), 0);
        chk("mr_fifo_rd", 32'(fifo_rd), 0);
        chk("mr_state", 32'(dut.state_q), 32'(ST_IDLE));
        p0 = pop_cnt;
        exp_q.delete();
        repeat (2) step();
        chk("mr_no_pops", pop_cnt - p0, 0);
        while (fifo_q.size() < HA * VA) push(24'h1F0000 + 24'(fifo_q.size()), 1'b0);
        exp_q = fifo_q;
        reset_rd = 1'b0;
        #1;
        chk("mr_first_pop_frame_start", 32'(fifo_rd), 1);
        p0 = pop_cnt;
        step();
        goto(0, VA + 1);
        chk("mr_frame_pops", pop_cnt - p0, HA * VA);
        chk("mr_sb_left", exp_q.size(), 0);
        chk("mr_end_idle", 32'(dut.state_q), 32'(ST_IDLE));

`ifdef VGA_TEST_PATTERN_EN
        // Colour bars, FIFO must be left untouched
        test_mode = 1'b1;
        for (int i = 0; i < 8; i++) push(24'h2A0000 + 24'(i), 1'b0);
        for (int r = 0; r < VA; r++)
            for (int b = 0; b < 8; b++) exp_q.push_back(bars[b]);
        p0 = pop_cnt;
        step();
        goto(0, VA + 1);
        chk("tp_no_pops", pop_cnt - p0, 0);
        chk("tp_state", 32'(dut.state_q), 32'(ST_IDLE));
        chk("tp_sb_left", exp_q.size(), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
